aud_rec_i2s_rx: RTL and testbench
=================================

// Module: aud_rec_i2s_rx
// PURPOSE
//  Receive-side counterpart of the DAC player: deserialises WM8731 ADC data (I2S, codec master, 16-bit).
//  Writes one channel's samples into sequential SRAM addresses.
//  Sits inside Top between the codec pins (AUD_ADCDAT/ADCLRCK) and the SRAM write port.
//  Runs on AUD_BCLK; key pulses from Top are already in this clock domain.
// PARAMETERS
//  DATA_W    16        sample width, MSB first
//  ADDR_W    20        SRAM word-address width
//  MAX_ADDR  20'hFFFFF last writable address; recording stops after it
//  CHANNEL   0         0 = left (LRCK low), 1 = right (LRCK high)
// PORTS
//  i_clk        in   1       AUD_BCLK; all logic on rising edge
//  i_rst_n      in   1       asynchronous, active-low reset
//  i_start      in   1       1-cycle pulse: start/resume recording
//  i_pause      in   1       1-cycle pulse: pause (address held)
//  i_stop       in   1       1-cycle pulse: stop, end of take
//  i_lrck       in   1       AUD_ADCLRCK
//  i_adcdat     in   1       AUD_ADCDAT
//  o_addr       out  ADDR_W  SRAM write address
//  o_data       out  DATA_W  SRAM write data
//  o_we         out  1       1-cycle write strobe; o_addr/o_data valid while high
//  o_last_addr  out  ADDR_W  address of last committed sample (handed to player)
//  o_recording  out  1       high in WAIT/SKIP/SHIFT
//  o_full       out  1       high once MAX_ADDR has been written
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; address counter 0; lrck_q 0.
//  Registers lrck_q <= i_lrck each cycle. Word edge: lrck_q != CHANNEL and i_lrck == CHANNEL.
//  FSM:
//   IDLE: i_start -> WAIT. Address counter cleared to 0, o_full cleared.
//   WAIT: word edge seen (edge E0) -> SKIP.
//    - Partial channel at start is never captured.
//    - E0 is the I2S one-bit delay slot; its bit is discarded.
//   SKIP: -> SHIFT, bit counter 0.
//    - Edges E1..E16 shift i_adcdat into shreg, MSB first.
//   SHIFT: on E16, latch the 16th bit:
//    - o_data <= {shreg[14:0], i_adcdat}; o_addr <= counter; o_we <= 1; o_last_addr <= counter.
//    - counter == MAX_ADDR: o_full <= 1 -> DONE.
//    - Otherwise counter++ -> WAIT.
//  o_we is high exactly one cycle (after E16); cleared on the next edge. Latency from E0 to strobe: 16 edges.
//  PAUSED: i_start -> WAIT; i_stop -> IDLE. Counter and o_last_addr held.
//  DONE: ignores audio and i_pause. i_start -> WAIT (new take from 0); i_stop -> IDLE with o_full kept.
//  i_pause in WAIT/SKIP/SHIFT -> PAUSED; partial word discarded; no o_we.
//  i_stop in any active state -> IDLE; partial word discarded; o_last_addr kept.
//  Priority on simultaneous pulses: i_stop > i_pause > i_start.
//  Pause/stop on the same edge as E16 wins: no write occurs.
//  Start from IDLE or DONE restarts at address 0; start from PAUSED resumes at counter.
//  LRCK toggling mid-SHIFT (glitch or short frame): abort word, no write.
//   - If it is a word edge, treat it as E0 and enter SKIP; otherwise go to WAIT.
//  Bits after E16 (DATA_W < slot width) are ignored until the next word edge.
//  Async reset at any point returns to IDLE immediately; o_we drops combinationally with reset.
// TESTING
//  1. Start; left word 16'hA5C3 after LRCK fall -> one o_we pulse after E16, o_addr=0, o_data=16'hA5C3.
//  2. Three frames, left 16'h0001/16'h8000/16'hFFFF, right 16'h1234 -> writes at addr 0,1,2 with those values.
//     Right word is never written; o_last_addr=2.
//  3. i_pause at E8 of frame 2 -> no write, counter 1.
//     i_start, next word 16'h5A5A -> o_addr=1, o_data=16'h5A5A.
//  4. MAX_ADDR=3 override, five frames -> writes 0..3, o_full=1, no 5th o_we.
//     i_start -> next write at addr 0, o_full=0.
//  5. i_stop and i_start on the same cycle while in WAIT -> IDLE, o_recording=0.
//     Then i_start -> first write at addr 0.
//  6. i_rst_n low at E10 of a word -> all outputs 0 immediately.
//     After release, no o_we until i_start plus a full frame.

Source files
------------

// File: rtl/aud_rec_i2s_rx.sv
// aud_rec_i2s_rx
// Deserialises one channel of WM8731 ADC audio (I2S framing, codec is the
// clock master, 16-bit words) and writes each captured sample to the next
// sequential SRAM word address. Everything runs on the rising edge of
// AUD_BCLK; the start/pause/stop pulses already live in this clock domain.
//
// Frame timing as seen on rising BCLK edges, for the selected channel:
//   E0      first edge where LRCK shows the selected channel; the bit on
//           this edge is the LSB of the previous word and is dropped
//   E1      MSB of our word (captured while the FSM sits in SKIP)
//   E2..E15 middle bits (captured in SHIFT)
//   E16     LSB; the word is committed and o_we pulses on the next cycle
// A 16-bit slot toggles LRCK on E16 itself, so the final-bit check takes
// priority over the "LRCK moved mid-word" abort inside SHIFT.

module aud_rec_i2s_rx #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}},
    parameter logic              CHANNEL  = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_lrck,
    input  logic              i_adcdat,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_last_addr,
    output logic              o_recording,
    output logic              o_full
);

    // Wide enough to hold the value DATA_W-1 ("bits collected so far").
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SKIP,
        S_SHIFT,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              lrck_q;

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [CNT_W-1:0]  bitCnt_d;

    logic [ADDR_W-1:0] addrCnt_q;
    logic [ADDR_W-1:0] addrCnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] lastAddr_q;
    logic [ADDR_W-1:0] lastAddr_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              we_q;
    logic              we_d;
    logic              full_q;
    logic              full_d;

    logic              wordEdge;
    logic              lrckToggle;
    logic              lastBit;
    logic              atMax;
    logic              newTake;
    logic              commit;

    // Per-edge events that both the FSM and the datapath key off.
    always_comb begin
        wordEdge   = (lrck_q != CHANNEL) && (i_lrck == CHANNEL);
        lrckToggle = (lrck_q != i_lrck);
        lastBit    = (bitCnt_q == CNT_W'(DATA_W - 1));
        atMax      = (addrCnt_q == MAX_ADDR);
        newTake    = ((state_q == S_IDLE) || (state_q == S_DONE)) && i_start && !i_stop;
        commit     = (state_q == S_SHIFT) && lastBit && !i_stop && !i_pause;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop beats pause beats start/audio events.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!i_stop && i_start) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSED;
                end else if (wordEdge) begin
                    state_d = S_SKIP;
                end
            end
            S_SKIP: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSED;
                end else if (lrckToggle) begin
                    state_d = wordEdge ? S_SKIP : S_WAIT;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSED;
                end else if (lastBit) begin
                    state_d = atMax ? S_DONE : S_WAIT;
                end else if (lrckToggle) begin
                    state_d = wordEdge ? S_SKIP : S_WAIT;
                end
            end
            S_PAUSED: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_start) begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_start) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM-derived and registered outputs; o_we is also gated by reset.
    always_comb begin
        o_recording = (state_q == S_WAIT) || (state_q == S_SKIP) || (state_q == S_SHIFT);
        o_we        = we_q & i_rst_n;
        o_addr      = addr_q;
        o_data      = data_q;
        o_last_addr = lastAddr_q;
        o_full      = full_q;
    end

    // Datapath next values: shifting, address counting and the write commit.
    always_comb begin
        shreg_d    = shreg_q;
        bitCnt_d   = bitCnt_q;
        addrCnt_d  = addrCnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        lastAddr_d = lastAddr_q;
        full_d     = full_q;
        we_d       = 1'b0;

        if (state_q == S_SKIP) begin
            shreg_d  = {shreg_q[DATA_W-2:0], i_adcdat};
            bitCnt_d = CNT_W'(1);
        end else if ((state_q == S_SHIFT) && !lastBit) begin
            shreg_d  = {shreg_q[DATA_W-2:0], i_adcdat};
            bitCnt_d = bitCnt_q + CNT_W'(1);
        end

        if (newTake) begin
            addrCnt_d = '0;
            full_d    = 1'b0;
        end

        if (commit) begin
            data_d     = {shreg_q[DATA_W-2:0], i_adcdat};
            addr_d     = addrCnt_q;
            lastAddr_d = addrCnt_q;
            we_d       = 1'b1;
            if (atMax) begin
                full_d = 1'b1;
            end else begin
                addrCnt_d = addrCnt_q + ADDR_W'(1);
            end
        end
    end

    // Datapath registers and the LRCK history bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_q     <= 1'b0;
            shreg_q    <= '0;
            bitCnt_q   <= '0;
            addrCnt_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            lastAddr_q <= '0;
            we_q       <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            lrck_q     <= i_lrck;
            shreg_q    <= shreg_d;
            bitCnt_q   <= bitCnt_d;
            addrCnt_q  <= addrCnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            lastAddr_q <= lastAddr_d;
            we_q       <= we_d;
            full_q     <= full_d;
        end
    end

endmodule

// File: tb/tb_aud_rec_i2s_rx.sv
// tb_aud_rec_i2s_rx
// Drives I2S frames (LRCK low = left slot, 16 BCLKs per slot, one-bit data
// delay) into the left-channel recorder with MAX_ADDR shrunk to 3, so the
// full/DONE behaviour is reached quickly.

module tb_aud_rec_i2s_rx;

    localparam int                DATA_W   = 16;
    localparam int                ADDR_W   = 20;
    localparam logic [ADDR_W-1:0] MAX_ADDR = 20'd3;

    localparam int P_NONE      = 0;
    localparam int P_START     = 1;
    localparam int P_PAUSE     = 2;
    localparam int P_STOP      = 3;
    localparam int P_STOPSTART = 4;

    localparam int M_IDLE   = 0;
    localparam int M_REC    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    typedef struct {
        logic [15:0]       left;
        logic [15:0]       right;
        int                pulse;
        int                pos;
        int                expWe;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expData;
        logic              expFull;
        logic              expRec;
        logic [ADDR_W-1:0] expLast;
    } vec_t;

    logic              clk = 1'b0;
    logic              rstN = 1'b1;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic              lrck = 1'b0;
    logic              adcdat = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
    logic [ADDR_W-1:0] lastAddr;
    logic              recording;
    logic              full;

    int                testsRun = 0;
    int                testsFailed = 0;
    logic              carry = 1'b0;
    logic [ADDR_W+DATA_W-1:0] gotQ[$];
    vec_t              vecs[$];

    int                mMode;
    logic [ADDR_W-1:0] mCnt;
    logic [ADDR_W-1:0] mLast;
    logic              mFull;

    aud_rec_i2s_rx #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR),
        .CHANNEL  (1'b0)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (start),
        .i_pause     (pause),
        .i_stop      (stop),
        .i_lrck      (lrck),
        .i_adcdat    (adcdat),
        .o_addr      (addr),
        .o_data      (data),
        .o_we        (we),
        .o_last_addr (lastAddr),
        .o_recording (recording),
        .o_full      (full)
    );

    // BCLK, 10 ns period.
    always #5 clk = ~clk;

    // Record every write strobe, sampled on the falling edge.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            gotQ.push_back({addr, data});
        end
    end

    // Guard against a hung run.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(logic [15:0] l, logic [15:0] r, int p, int ps,
                                   int ew, logic [ADDR_W-1:0] ea, logic [DATA_W-1:0] ed,
                                   logic ef, logic er, logic [ADDR_W-1:0] el);
        vec_t v;
        v.left = l; v.right = r; v.pulse = p; v.pos = ps;
        v.expWe = ew; v.expAddr = ea; v.expData = ed;
        v.expFull = ef; v.expRec = er; v.expLast = el;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One BCLK period: change LRCK/data/pulses on the falling edge.
    task automatic driveBit(input logic lr, input logic d, input int kind);
        @(negedge clk);
        lrck   = lr;
        adcdat = d;
        start  = (kind == P_START) || (kind == P_STOPSTART);
        pause  = (kind == P_PAUSE);
        stop   = (kind == P_STOP) || (kind == P_STOPSTART);
    endtask

    // One 16-BCLK slot; the previous word's LSB rides on the first bit.
    task automatic sendSlot(input logic ch, input logic [15:0] w, input int kind, input int pos);
        logic b;
        for (int p = 0; p < 16; p++) begin
            if (p == 0) b = carry;
            else        b = w[16-p];
            driveBit(ch, b, (p == pos) ? kind : P_NONE);
        end
        carry = w[0];
    endtask

    // One full frame with an optional pulse at frame position pos (0..31).
    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input int kind, input int pos);
        sendSlot(1'b0, l, (pos < 16) ? kind : P_NONE, pos);
        sendSlot(1'b1, r, (pos >= 16) ? kind : P_NONE, pos - 16);
    endtask

    task automatic checkOutput(input string tag, input int expWe, input logic [ADDR_W-1:0] ea,
                               input logic [DATA_W-1:0] ed, input logic ef, input logic er,
                               input logic [ADDR_W-1:0] el);
        int n;
        @(posedge clk);
        #1;
        n = gotQ.size();
        checkVal({tag, ".writes"}, n, expWe);
        if (n > 0 && expWe > 0) begin
            checkVal({tag, ".addr"}, 32'(gotQ[0][ADDR_W+DATA_W-1:DATA_W]), 32'(ea));
            checkVal({tag, ".data"}, 32'(gotQ[0][DATA_W-1:0]), 32'(ed));
        end
        gotQ.delete();
        checkVal({tag, ".full"}, 32'(full), 32'(ef));
        checkVal({tag, ".rec"}, 32'(recording), 32'(er));
        checkVal({tag, ".last"}, 32'(lastAddr), 32'(el));
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".addr"}, 32'(addr), 32'd0);
        checkVal({tag, ".data"}, 32'(data), 32'd0);
        checkVal({tag, ".we"}, 32'(we), 32'd0);
        checkVal({tag, ".last"}, 32'(lastAddr), 32'd0);
        checkVal({tag, ".rec"}, 32'(recording), 32'd0);
        checkVal({tag, ".full"}, 32'(full), 32'd0);
    endtask

    task automatic doReset();
        start = 0; pause = 0; stop = 0; lrck = 0; adcdat = 0; carry = 0;
        rstN = 1'b1;
        #1;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rstN = 1'b1;
        gotQ.delete();
    endtask

    // Reference model: recorder mode, next address, full flag, last address.
    function automatic void modelPulse(input int kind);
        case (kind)
            P_START: begin
                if (mMode == M_IDLE || mMode == M_DONE) begin
                    mCnt  = '0;
                    mFull = 1'b0;
                end
                mMode = M_REC;
            end
            P_PAUSE: if (mMode == M_REC) mMode = M_PAUSED;
            P_STOP, P_STOPSTART: mMode = M_IDLE;
            default: ;
        endcase
    endfunction

    task automatic randomFrame(input int idx);
        logic [15:0]       l, r;
        int                kind, k, sel, ew;
        logic              canCap;
        logic [ADDR_W-1:0] ea;
        l   = 16'($urandom);
        r   = 16'($urandom);
        sel = $urandom_range(0, 11);
        kind = (sel < 6) ? P_NONE : (sel < 8) ? P_START : (sel < 10) ? P_PAUSE :
               (sel < 11) ? P_STOP : P_STOPSTART;
        k   = $urandom_range(0, 31);
        // A left word survives only if recording at E0 and no pause/stop lands on E0..E16.
        canCap = (mMode == M_REC) && !((kind == P_PAUSE || kind == P_STOP || kind == P_STOPSTART) && k <= 16);
        ew = 0;
        ea = '0;
        if (k <= 16) modelPulse(kind);
        if (canCap) begin
            ew    = 1;
            ea    = mCnt;
            mLast = mCnt;
            if (mCnt == MAX_ADDR) begin
                mFull = 1'b1;
                mMode = M_DONE;
            end else begin
                mCnt = mCnt + 1'b1;
            end
        end
        if (k > 16) modelPulse(kind);
        applyStimulus(l, r, kind, k);
        checkOutput($sformatf("rnd%0d", idx), ew, ea, l, mFull, (mMode == M_REC), mLast);
    endtask

    initial begin
        logic [15:0] w;

        // Directed frames (MAX_ADDR = 3); expected values worked out by hand.
        vecs.push_back(mkVec(16'hA5C3, 16'h1111, P_STOP,      21, 1, 20'd0, 16'hA5C3, 0, 0, 20'd0));
        vecs.push_back(mkVec(16'h0BAD, 16'h2222, P_START,     21, 0, 20'd0, 16'h0000, 0, 1, 20'd0));
        vecs.push_back(mkVec(16'h0001, 16'h1234, P_NONE,       0, 1, 20'd0, 16'h0001, 0, 1, 20'd0));
        vecs.push_back(mkVec(16'h8000, 16'h1234, P_NONE,       0, 1, 20'd1, 16'h8000, 0, 1, 20'd1));
        vecs.push_back(mkVec(16'hFFFF, 16'h1234, P_NONE,       0, 1, 20'd2, 16'hFFFF, 0, 1, 20'd2));
        vecs.push_back(mkVec(16'h7777, 16'h3333, P_PAUSE,      8, 0, 20'd0, 16'h0000, 0, 0, 20'd2));
        vecs.push_back(mkVec(16'h6666, 16'h4444, P_START,     19, 0, 20'd0, 16'h0000, 0, 1, 20'd2));
        vecs.push_back(mkVec(16'h5A5A, 16'h5555, P_NONE,       0, 1, 20'd3, 16'h5A5A, 1, 0, 20'd3));
        vecs.push_back(mkVec(16'h1357, 16'h2468, P_NONE,       0, 0, 20'd0, 16'h0000, 1, 0, 20'd3));
        vecs.push_back(mkVec(16'h4444, 16'h0000, P_PAUSE,      3, 0, 20'd0, 16'h0000, 1, 0, 20'd3));
        vecs.push_back(mkVec(16'h2468, 16'h0000, P_START,     23, 0, 20'd0, 16'h0000, 0, 1, 20'd3));
        vecs.push_back(mkVec(16'hC0DE, 16'h0000, P_NONE,       0, 1, 20'd0, 16'hC0DE, 0, 1, 20'd0));
        vecs.push_back(mkVec(16'hBEEF, 16'h0000, P_STOPSTART, 18, 1, 20'd1, 16'hBEEF, 0, 0, 20'd1));
        vecs.push_back(mkVec(16'h1111, 16'h0000, P_START,     18, 0, 20'd0, 16'h0000, 0, 1, 20'd1));
        vecs.push_back(mkVec(16'hABCD, 16'h0000, P_NONE,       0, 1, 20'd0, 16'hABCD, 0, 1, 20'd0));
        vecs.push_back(mkVec(16'h4321, 16'h0000, P_PAUSE,     16, 0, 20'd0, 16'h0000, 0, 0, 20'd0));
        vecs.push_back(mkVec(16'h0000, 16'h0000, P_START,     21, 0, 20'd0, 16'h0000, 0, 1, 20'd0));
        vecs.push_back(mkVec(16'h9999, 16'h0000, P_NONE,       0, 1, 20'd1, 16'h9999, 0, 1, 20'd1));
        vecs.push_back(mkVec(16'h2222, 16'h0000, P_STOP,      16, 0, 20'd0, 16'h0000, 0, 0, 20'd1));
        vecs.push_back(mkVec(16'h3333, 16'h0000, P_START,     20, 0, 20'd0, 16'h0000, 0, 1, 20'd1));
        vecs.push_back(mkVec(16'h6C6C, 16'h0000, P_NONE,       0, 1, 20'd0, 16'h6C6C, 0, 1, 20'd0));

        doReset();

        // Lead-in right slot carries the first start pulse and the first LRCK high.
        sendSlot(1'b1, 16'h0000, P_START, 2);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].left, vecs[i].right, vecs[i].pulse, vecs[i].pos);
            checkOutput($sformatf("v%0d", i), vecs[i].expWe, vecs[i].expAddr, vecs[i].expData,
                        vecs[i].expFull, vecs[i].expRec, vecs[i].expLast);
        end

        // LRCK glitch mid-word: junk word aborted, the re-edge acts as E0.
        for (int p = 0; p < 6; p++) driveBit(1'b0, 1'b1, P_NONE);
        driveBit(1'b1, 1'b0, P_NONE);
        driveBit(1'b0, 1'b1, P_NONE);
        w = 16'h6C39;
        for (int p = 1; p < 16; p++) driveBit(1'b0, w[16-p], P_NONE);
        driveBit(1'b1, w[0], P_NONE);
        for (int p = 1; p < 16; p++) driveBit(1'b1, 1'b1, P_NONE);
        carry = 1'b1;
        checkOutput("glitch", 1, 20'd1, 16'h6C39, 0, 1, 20'd1);

        // Asynchronous reset at E10 of a word clears every output at once.
        for (int p = 0; p <= 10; p++) driveBit(1'b0, p[0], P_NONE);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkAllZero("midReset");
        repeat (2) @(negedge clk);
        rstN  = 1'b1;
        carry = 1'b0;
        gotQ.delete();
        sendSlot(1'b1, 16'h0000, P_NONE, 0);
        applyStimulus(16'h0F0F, 16'h0000, P_NONE, 0);
        checkOutput("postRstIdle", 0, 20'd0, 16'h0000, 0, 0, 20'd0);
        applyStimulus(16'h1E1E, 16'h0000, P_START, 20);
        checkOutput("postRstStart", 0, 20'd0, 16'h0000, 0, 1, 20'd0);
        applyStimulus(16'hF00D, 16'h0000, P_NONE, 0);
        checkOutput("postRstWrite", 1, 20'd0, 16'hF00D, 0, 1, 20'd0);

        // Randomised frames and pulses against the mode-level model.
        doReset();
        mMode = M_IDLE;
        mCnt  = '0;
        mLast = '0;
        mFull = 1'b0;
        sendSlot(1'b1, 16'h0000, P_START, 2);
        modelPulse(P_START);
        checkOutput("rndLeadIn", 0, 20'd0, 16'h0000, mFull, 1'b1, mLast);
        for (int i = 0; i < 80; i++) begin
            randomFrame(i);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
